// File: rtl/buzzer_pkg.sv
// ---------------------------------------------------------------------------
// buzzer_pkg
// Shared definitions for the Buzzer note prefetcher:
//   - AHB-Lite transfer-type and size encodings used by the fetch master
//   - note entry field positions and the end-of-song nibble
//   - the prefetch FSM state type
//   - is_marker(): true when a 16-bit note entry is the end-of-song marker
// ---------------------------------------------------------------------------
package buzzer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [3:0] NOTE_END_NIB  = 4'hF;

    // Note entry layout: [15:12] marker nibble, [11:8] beat, [7:0] tune
    localparam int NOTE_MARK_MSB = 15;
    localparam int NOTE_MARK_LSB = 12;
    localparam int NOTE_BEAT_MSB = 11;
    localparam int NOTE_BEAT_LSB = 8;
    localparam int NOTE_TUNE_MSB = 7;
    localparam int NOTE_TUNE_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        END,
        DRAIN
    } state_t;

    function automatic logic is_marker(input logic [15:0] entry);
        return entry[NOTE_MARK_MSB:NOTE_MARK_LSB] == NOTE_END_NIB;
    endfunction

endpackage

// File: rtl/note_prefetch_if.sv
// ---------------------------------------------------------------------------
// note_prefetch_if
// Bundles the AHB-Lite read-master signals and the note valid/ready stream
// of the Buzzer note prefetcher.
//   master modport : the prefetcher (drives HADDR/HTRANS/HWRITE/HSIZE and
//                    note_valid/note_data; receives HRDATA/HREADY/note_ready)
//   slave modport  : the memory + channel-controller side
// ---------------------------------------------------------------------------
interface note_prefetch_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA;
    logic        HREADY;

    logic        note_valid;
    logic [15:0] note_data;
    logic        note_ready;

    modport master (
        output HADDR,
        output HTRANS,
        output HWRITE,
        output HSIZE,
        input  HRDATA,
        input  HREADY,
        output note_valid,
        output note_data,
        input  note_ready
    );

    modport slave (
        input  HADDR,
        input  HTRANS,
        input  HWRITE,
        input  HSIZE,
        output HRDATA,
        output HREADY,
        input  note_valid,
        input  note_data,
        output note_ready
    );

endinterface

// File: rtl/note_fifo.sv
// ---------------------------------------------------------------------------
// note_fifo
// Small synchronous FIFO of 16-bit note entries that accepts 0, 1 or 2
// pushes and 1 pop in the same cycle. Built as a shift register so that the
// head entry and the valid flag come straight out of flops.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             empty the FIFO (wins over push and pop)
//   push_n[1:0]       number of entries to push this cycle (0..2)
//   push_lo, push_hi  first and second entry pushed
//   pop               remove the head entry (only while valid)
//   count             number of stored entries
//   head              head entry (zero when empty after reset/flush)
//   valid             FIFO not empty
// ---------------------------------------------------------------------------
module note_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [1:0]                 push_n,
    input  logic [15:0]                push_lo,
    input  logic [15:0]                push_hi,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                head,
    output logic                       valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   mem_reg   [DEPTH];
    logic [15:0]   slot_next [DEPTH];
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [CW-1:0] wr_base;
    logic          valid_reg;

    // Pushed entries land just behind whatever survives this cycle's pop.
    assign wr_base    = count_reg - CW'(pop);
    assign count_next = wr_base + CW'(push_n);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [15:0] shifted;
        if (gi < DEPTH - 1) begin : g_mid
            assign shifted = pop ? mem_reg[gi + 1] : mem_reg[gi];
        end else begin : g_last
            assign shifted = pop ? 16'h0000 : mem_reg[gi];
        end
        assign slot_next[gi] =
            ((push_n != 2'd0) && (wr_base == CW'(gi)))             ? push_lo :
            ((push_n == 2'd2) && ((wr_base + CW'(1)) == CW'(gi)))  ? push_hi :
                                                                     shifted;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= slot_next[i];
            end
            count_reg <= count_next;
            valid_reg <= (count_next != '0);
        end
    end

    assign count = count_reg;
    assign head  = mem_reg[0];
    assign valid = valid_reg;

endmodule

// File: rtl/note_prefetch.sv
// ---------------------------------------------------------------------------
// note_prefetch
// Upstream feeder for one Buzzer playback channel. Reads packed note words
// over AHB-Lite (one single transfer outstanding), splits each word into two
// 16-bit entries (low half first), buffers them in note_fifo and presents
// them on a valid/ready stream. Fetching stops at the end-of-song marker and
// done pulses once the consumer takes that marker.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        pulse: latch base_addr and begin fetching (IDLE only)
//   stop         pulse: abort fetching and flush; beats start
//   base_addr    word address of the first note word ([1:0] ignored)
//   busy         block not idle
//   done         one-cycle pulse after the marker handshake
//   bus          AHB-Lite master + note stream (note_prefetch_if.master)
// ---------------------------------------------------------------------------
module note_prefetch
    import buzzer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [31:0]     base_addr,
    output logic            busy,
    output logic            done,
    note_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_reg;
    logic [31:0]   ptr_reg;
    logic [31:0]   haddr_reg;
    logic [1:0]    htrans_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_after;
    logic [15:0]   fifo_head;
    logic          fifo_valid;

    logic [31:0]   start_addr;
    logic [31:0]   ptr_inc;
    logic          lo_mark;
    logic          hi_mark;
    logic          song_end;
    logic          addr_accepted;
    logic          data_done;
    logic          pop;
    logic          flush;
    logic          room;
    logic [1:0]    push_n;

    assign start_addr    = base_addr & ~32'h0000_0003;
    assign ptr_inc       = ptr_reg + 32'd4;

    assign lo_mark       = is_marker(bus.HRDATA[15:0]);
    assign hi_mark       = is_marker(bus.HRDATA[31:16]);
    assign song_end      = lo_mark | hi_mark;

    assign addr_accepted = (state_reg == ADDR) && (htrans_reg == HTRANS_NONSEQ) && bus.HREADY;
    assign data_done     = (state_reg == DATA) && bus.HREADY && !stop;

    // A marker in the low half ends the song; the high half is never stored.
    assign push_n        = !data_done ? 2'd0 : (lo_mark ? 2'd1 : 2'd2);
    assign pop           = fifo_valid & bus.note_ready;

    // start flushes leftovers from IDLE; stop flushes from any busy state.
    assign flush         = stop ? (state_reg != IDLE) : ((state_reg == IDLE) && start);

    // Occupancy after this cycle's push/pop decides whether the next cycle
    // may issue a fetch. Until that word returns the FIFO can only drain, so
    // two free slots now guarantee both halves fit on arrival.
    assign count_after   = flush ? '0 : (fifo_count + CW'(push_n) - CW'(pop));
    assign room          = count_after <= CW'(DEPTH - 2);

    note_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push_n  (push_n),
        .push_lo (bus.HRDATA[15:0]),
        .push_hi (bus.HRDATA[31:16]),
        .pop     (pop),
        .count   (fifo_count),
        .head    (fifo_head),
        .valid   (fifo_valid)
    );

    // HTRANS/HADDR are computed one cycle ahead so the bus sees registered
    // values: the NONSEQ for the next word is launched on the same edge that
    // captures the current word, giving one word every two cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            haddr_reg  <= '0;
            htrans_reg <= HTRANS_IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !stop) begin
                        ptr_reg    <= start_addr;
                        haddr_reg  <= start_addr;
                        htrans_reg <= HTRANS_NONSEQ;
                        state_reg  <= ADDR;
                        busy_reg   <= 1'b1;
                    end
                end
                ADDR: begin
                    if (addr_accepted) begin
                        htrans_reg <= HTRANS_IDLE;
                        state_reg  <= stop ? DRAIN : DATA;
                    end else if (stop) begin
                        htrans_reg <= HTRANS_IDLE;
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                    end else if ((htrans_reg == HTRANS_IDLE) && room) begin
                        htrans_reg <= HTRANS_NONSEQ;
                        haddr_reg  <= ptr_reg;
                    end
                end
                DATA: begin
                    if (stop) begin
                        if (bus.HREADY) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= DRAIN;
                        end
                    end else if (bus.HREADY) begin
                        ptr_reg <= ptr_inc;
                        if (song_end) begin
                            state_reg <= END;
                        end else begin
                            state_reg <= ADDR;
                            if (room) begin
                                htrans_reg <= HTRANS_NONSEQ;
                                haddr_reg  <= ptr_inc;
                            end
                        end
                    end
                end
                END: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (pop && is_marker(fifo_head)) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The aborted transfer must still complete on the bus.
                    if (bus.HREADY) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    htrans_reg <= HTRANS_IDLE;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HADDR      = haddr_reg;
    assign bus.HTRANS     = htrans_reg;
    assign bus.HWRITE     = 1'b0;
    assign bus.HSIZE      = HSIZE_WORD;
    assign bus.note_valid = fifo_valid;
    assign bus.note_data  = fifo_head;
    assign busy           = busy_reg;
    assign done           = done_reg;

endmodule
